// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states,
// the iteration count, and the per-operation context captured at start.
package mdu_pkg;
  localparam int ITERS = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_t;

  // neg_q doubles as the product-negate flag for multiplies
  typedef struct packed {
    logic is_div;
    logic neg_q;
    logic neg_r;
    logic dz;
  } ctx_t;
endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on {hi,lo}.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    // remainder < divisor always, so {rem,next bit} fits in WIDTH+1 bits
    trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    acc_nxt = {sum, acc[WIDTH-1:1]};
    if (is_div)
      acc_nxt = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                             : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end
endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = ITERS,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] DR1,
  input  logic [WIDTH-1:0] DR2,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] mt_data,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);
  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc, acc_nxt;
  logic [WIDTH-1:0]     opnd, rs_raw;
  ctx_t                 ctx;

  logic                 is_signed, is_div_in, s1, s2;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     q, r, hi_res, lo_res;

  // abs(most-negative) wraps to itself, which is the right unsigned magnitude
  always_comb begin
    is_signed = ~op[0];
    is_div_in = op[1];
    s1        = is_signed & DR1[WIDTH-1];
    s2        = is_signed & DR2[WIDTH-1];
    mag1      = s1 ? -DR1 : DR1;
    mag2      = s2 ? -DR2 : DR2;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .opnd    (opnd),
    .is_div  (ctx.is_div),
    .acc_nxt (acc_nxt)
  );

  always_comb begin
    prod   = ctx.neg_q ? -acc : acc;
    q      = acc[WIDTH-1:0];
    r      = acc[2*WIDTH-1:WIDTH];
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (ctx.is_div) begin
      lo_res = ctx.neg_q ? -q : q;
      hi_res = ctx.neg_r ? -r : r;
      if (ctx.dz) begin
        lo_res = {WIDTH{1'b1}};
        hi_res = rs_raw;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      rs_raw <= '0;
      ctx    <= '0;
      HI     <= '0;
      LO     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc        <= is_div_in ? {{WIDTH{1'b0}}, mag1} : {{WIDTH{1'b0}}, mag2};
            opnd       <= is_div_in ? mag2 : mag1;
            rs_raw     <= DR1;
            ctx.is_div <= is_div_in;
            ctx.neg_q  <= s1 ^ s2;
            ctx.neg_r  <= s1;
            ctx.dz     <= is_div_in & (DR2 == '0);
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= ST_CALC;
          end else begin
            if (mthi) HI <= mt_data;
            if (mtlo) LO <= mt_data;
          end
        end
        ST_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) state <= ST_FIX;
        end
        ST_FIX: begin
          HI    <= hi_res;
          LO    <= lo_res;
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] DR1 = '0, DR2 = '0, mt_data = '0;
  logic        mthi = 1'b0, mtlo = 1'b0;
  logic [31:0] HI, LO;
  logic        busy, done;
  int          checks = 0;
  int          errors = 0;

  mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .DR1(DR1), .DR2(DR2),
    .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
    .HI(HI), .LO(LO), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, b,
                        input logic [31:0] ehi, elo, input int mode);
    int n;
    bit seen;
    logic [31:0] lo_prev;
    @(negedge clk);
    op = o; DR1 = a; DR2 = b; start = 1'b1;
    lo_prev = LO; n = 0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0; mtlo = 1'b0;
      if (done) begin seen = 1'b1; break; end
      if (busy) n++;
      if (mode == 1 && n == 10) begin start = 1'b1; op = OP_MULTU; DR1 = 32'd3; DR2 = 32'd3; end
      if (mode == 2 && n == 5) begin mtlo = 1'b1; mt_data = 32'hDEADBEEF; end
      if (mode == 2 && n == 7) chk({tag, "_lo_mid"}, LO, lo_prev);
    end
    chk({tag, "_done"}, seen, 1'b1);
    chk({tag, "_busycyc"}, n, 33);
    chk({tag, "_hi"}, HI, ehi);
    chk({tag, "_lo"}, LO, elo);
    @(negedge clk);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;

    run_op("mult_m3x5", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
    run_op("div_m7d2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    run_op("divu_dz", OP_DIVU, 32'd7, 32'd0, 32'h00000007, 32'hFFFFFFFF, 0);
    run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1);

    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h12345678;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    chk("mt_both_hi", HI, 32'h12345678);
    chk("mt_both_lo", LO, 32'h12345678);
    chk("mt_both_done", done, 1'b0);
    mtlo = 1'b1; mt_data = 32'h9ABCDEF0;
    @(negedge clk); mtlo = 1'b0;
    chk("mtlo_lo", LO, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", HI, 32'h12345678);
    chk("mtlo_done", done, 1'b0);

    run_op("multu_mtlo_busy", OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 2);

    @(negedge clk); op = OP_MULT; DR1 = 32'h1234; DR2 = 32'h5678; start = 1'b1;
    repeat (15) begin @(negedge clk); start = 1'b0; end
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_hi", HI, 32'h0);
    chk("arst_lo", LO, 32'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    @(negedge clk); rst = 1'b0;

    run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
